// File: rtl/demux_pkg.sv
// Shared constants and types for the 1:4 registered stream demultiplexer.
package demux_pkg;
  localparam int N_CH  = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 8;

  typedef logic [SEL_W-1:0] ch_sel_t;
endpackage

// File: rtl/demux_out_slot.sv
// One-entry output slot: a load overrides a drain in the same cycle.
// With DEMUX_STATS_EN defined, also keeps a saturating count of loads.
module demux_out_slot
  import demux_pkg::*;
#(
  parameter int W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [W-1:0]     data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [W-1:0]     data_o
`ifdef DEMUX_STATS_EN
  ,
  output logic [CNT_W-1:0] count_o
`endif
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

`ifdef DEMUX_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturates at all-ones so a busy channel never wraps back to a small count.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;
`endif

endmodule

// File: rtl/demux_1_4_stream.sv
// 1:4 registered stream demultiplexer with per-channel one-entry slots.
// Optional per-channel accept counters under DEMUX_STATS_EN.
module demux_1_4_stream
  import demux_pkg::*;
#(
  parameter int W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          in_data,
  input  ch_sel_t               in_sel,
  output logic [N_CH-1:0]       out_valid,
  input  logic [N_CH-1:0]       out_ready,
  output logic [W-1:0]          out_data0,
  output logic [W-1:0]          out_data1,
  output logic [W-1:0]          out_data2,
  output logic [W-1:0]          out_data3
`ifdef DEMUX_STATS_EN
  ,
  output logic [N_CH*CNT_W-1:0] ch_count
`endif
);

  logic [N_CH-1:0] vld_w;
  logic [N_CH-1:0] load_w;
  logic [W-1:0]    data_w [N_CH];
  logic            acc_w;

  // Only the selected slot gates the input, so a stalled channel blocks
  // nothing else; a full slot being drained this cycle can take a refill.
  assign in_ready = ~vld_w[in_sel] | out_ready[in_sel];
  assign acc_w    = in_valid & in_ready;

  always_comb begin
    load_w = '0;
    if (acc_w) load_w[in_sel] = 1'b1;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_slot
`ifdef DEMUX_STATS_EN
    demux_out_slot #(.W(W)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load_w[i]),
      .data_i  (in_data),
      .ready_i (out_ready[i]),
      .valid_o (vld_w[i]),
      .data_o  (data_w[i]),
      .count_o (ch_count[i*CNT_W +: CNT_W])
    );
`else
    demux_out_slot #(.W(W)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load_w[i]),
      .data_i  (in_data),
      .ready_i (out_ready[i]),
      .valid_o (vld_w[i]),
      .data_o  (data_w[i])
    );
`endif
  end

  assign out_valid = vld_w;
  assign out_data0 = data_w[0];
  assign out_data1 = data_w[1];
  assign out_data2 = data_w[2];
  assign out_data3 = data_w[3];

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Self-checking bench for demux_1_4_stream: vector table plus per-channel
// scoreboard queues; the counter check runs when DEMUX_STATS_EN is defined.
module tb_demux_1_4_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [1:0] in_sel;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [3:0] out_data0, out_data1, out_data2, out_data3;
`ifdef DEMUX_STATS_EN
  logic [31:0] ch_count;
`endif

  always #5 clk = ~clk;

  demux_1_4_stream #(.W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3)
`ifdef DEMUX_STATS_EN
    ,
    .ch_count  (ch_count)
`endif
  );

  logic [3:0] od [4];
  assign od[0] = out_data0;
  assign od[1] = out_data1;
  assign od[2] = out_data2;
  assign od[3] = out_data3;

  typedef struct {
    logic       iv;
    logic [1:0] sel;
    logic [3:0] d;
    logic [3:0] ordy;
    logic       rdy;   // expected in_ready during the cycle
    logic [3:0] vld;   // expected out_valid after the edge
  } vec_t;

  vec_t       tbl [$];
  logic [3:0] sbq [4][$];
  logic [3:0] model_vld;
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic iv, input logic [1:0] sel, input logic [3:0] d,
                     input logic [3:0] ordy, input logic rdy, input logic [3:0] vld);
    vec_t v;
    v.iv = iv; v.sel = sel; v.d = d; v.ordy = ordy; v.rdy = rdy; v.vld = vld;
    tbl.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    logic [3:0] e;
    in_valid  = v.iv;
    in_sel    = v.sel;
    in_data   = v.d;
    out_ready = v.ordy;
    #1;
    check("in_ready", {31'd0, in_ready}, {31'd0, v.rdy});
    for (int i = 0; i < 4; i++) begin
      if (model_vld[i] && v.ordy[i]) begin
        if (sbq[i].size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL drain_ch%0d: got %0h expected <no word>", i, od[i]);
        end else begin
          e = sbq[i].pop_front();
          check($sformatf("drain_data_ch%0d", i), {28'd0, od[i]}, {28'd0, e});
        end
      end
    end
    if (v.iv && v.rdy) sbq[v.sel].push_back(v.d);
    @(posedge clk);
    #1;
    check("out_valid", {28'd0, out_valid}, {28'd0, v.vld});
    if (v.iv && v.rdy) check($sformatf("load_data_ch%0d", v.sel), {28'd0, od[v.sel]}, {28'd0, v.d});
    model_vld = v.vld;
  endtask

  task automatic check_empty(input string nm);
    check({nm, "_valid"}, {28'd0, out_valid}, 32'd0);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_data%0d", nm, i), {28'd0, od[i]}, 32'd0);
  endtask

  task automatic flush_model();
    for (int i = 0; i < 4; i++) sbq[i].delete();
    model_vld = 4'b0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = 4'd0; out_ready = 4'b0000;
    flush_model();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    check_empty("reset");
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);

    // fill all four channels with backpressure
    add(1, 0, 4'hA, 4'b0000, 1, 4'b0001);
    add(1, 1, 4'hB, 4'b0000, 1, 4'b0011);
    add(1, 2, 4'hC, 4'b0000, 1, 4'b0111);
    add(1, 3, 4'hD, 4'b0000, 1, 4'b1111);
    for (int s = 0; s < 4; s++) add(0, 2'(s), 4'h3, 4'b0000, 0, 4'b1111);
    // stall on channel 2, drain channel 1 and refill it
    add(1, 2, 4'h5, 4'b0000, 0, 4'b1111);
    add(0, 1, 4'h0, 4'b0010, 1, 4'b1101);
    add(1, 1, 4'h7, 4'b0000, 1, 4'b1111);
    // pass-through refill on channel 3
    add(1, 3, 4'hE, 4'b1000, 1, 4'b1111);
    // four drains plus one accept in the same cycle
    add(1, 2, 4'hF, 4'b1111, 1, 4'b0100);
    add(0, 0, 4'h0, 4'b1111, 1, 4'b0000);
    // full-rate streaming
    for (int k = 0; k < 8; k++) add(1, 2'(k % 4), 4'(k + 1), 4'b1111, 1, 4'(1 << (k % 4)));
    add(0, 0, 4'h0, 4'b1111, 1, 4'b0000);
    // stalled channel 2 only blocks when selected
    add(1, 2, 4'h9, 4'b0000, 1, 4'b0100);
    add(1, 0, 4'h1, 4'b0001, 1, 4'b0101);
    add(1, 0, 4'h2, 4'b0001, 1, 4'b0101);
    add(1, 2, 4'h3, 4'b0001, 0, 4'b0100);
    add(0, 0, 4'h0, 4'b1111, 1, 4'b0000);

    foreach (tbl[i]) apply(tbl[i]);

    // asynchronous reset with all slots full
    tbl.delete();
    add(1, 0, 4'h6, 4'b0000, 1, 4'b0001);
    add(1, 1, 4'h7, 4'b0000, 1, 4'b0011);
    add(1, 2, 4'h8, 4'b0000, 1, 4'b0111);
    add(1, 3, 4'h9, 4'b0000, 1, 4'b1111);
    foreach (tbl[i]) apply(tbl[i]);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_empty("async_reset");
    @(posedge clk);
    #2 rst = 1'b0;
    flush_model();
    #1;
    check("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

`ifdef DEMUX_STATS_EN
    @(posedge clk);
    #1;
    check("count_after_reset", ch_count, 32'd0);
    in_valid = 1'b1; in_sel = 2'd0; in_data = 4'h4; out_ready = 4'b1111;
    repeat (300) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("count_saturate", ch_count, 32'h0000_00FF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/demux_1_4_stream.md
Name: demux_1_4_stream

Overview:
- 1:4 registered stream demultiplexer, the distribution counterpart of the 4:1 index mux.
- One input stream with a 2-bit destination index; each word is steered into one of four output channels.
- Each output channel has a one-entry holding slot with valid/ready handshake.
- Sits between a single producer and four independent consumers (e.g. per-digit display drivers, per-lane FIFOs).

Parameters:
- W, 4, data width of the input and of each output channel.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer offers a word.
- in_ready  output  1  block accepts the offered word this cycle.
- in_data  input  W  word to route.
- in_sel  input  2  destination channel index, 0..3.
- out_valid  output  4  bit i set: channel i slot holds a word.
- out_ready  input  4  bit i set: consumer i takes the word this cycle.
- out_data0..out_data3  output  W each  channel slot contents.

Behaviour:
- Reset (async assert, sync release): out_valid = 0, all out_dataN = 0. in_ready follows the combinational rule below, so it is 1 after reset.
- Accept: acc = in_valid & in_ready. Drain on channel i: drn[i] = out_valid[i] & out_ready[i].
- in_ready = ~out_valid[in_sel] | out_ready[in_sel]. This is combinational and depends only on the selected channel. A full slot whose consumer is ready accepts a new word in the same cycle (pass-through refill, full throughput).
- Slot i next state:
  - if acc and in_sel == i: out_valid[i] <= 1, out_data_i <= in_data. Takes priority over drain.
  - else if drn[i]: out_valid[i] <= 0; data holds its last value.
  - else: hold.
- Latency: word accepted at edge k appears on out_dataN / out_valid at the output after edge k.
- Non-selected channels are never disturbed by an accept; their drains proceed independently in the same cycle.
- Simultaneous drains on all four channels plus one accept: all four handled in one cycle.
- in_sel and in_data are ignored when in_valid = 0. in_ready is still driven from the current in_sel.
- Backpressure isolation: a stalled channel blocks the input only while in_sel points to it. Words for other channels still flow.
- Ordering: per channel, words leave in acceptance order (depth 1, so trivially).
- Async reset mid-transfer: all slots empty immediately, in-flight words discarded. No output X after reset.
- X on in_sel with in_valid = 1: no requirement on outputs. The bench must not drive this.

Optional Feature:
- Macro DEMUX_STATS_EN.
- Defined:
  - adds output port ch_count  output  4x8 (packed, channel 0 in bits [7:0]).
  - per-channel saturating count of accepted words; reset to 0.
  - increments on acc with matching in_sel; sticks at 255.
- Undefined: port and counters absent; routing behaviour identical.

Decomposition:
- Package demux_pkg holds:
  - localparam N_CH = 4;
  - localparam SEL_W = 2;
  - localparam CNT_W = 8;
  - typedef logic [SEL_W-1:0] ch_sel_t.
- Sub-module demux_out_slot, instanced 4 times:
  - one-entry register with load/drain priority;
  - optional counter under DEMUX_STATS_EN.
- Top level contains:
  - index decode into one-hot load enables;
  - in_ready mux, written as an array index like the 4:1 mux;
  - generate loop over the slots.

Test Plan:
- After rst pulse: out_valid = 0000, in_ready = 1, all out_dataN = 0. Assert rst mid-run with slots full: out_valid drops to 0000 without waiting for a clock edge.
- out_ready = 0000; send a,b,c,d to sel 0,1,2,3 → out_valid = 1111, out_data0..3 = a,b,c,d; in_ready = 0 for every sel value.
- Channel 2 full and out_ready = 0000; send sel=2 with in_data = 5 → in_ready = 0, out_data2 unchanged. Then send sel=1 with in_data = 7 → accepted, out_data1 = 7.
- Channel 3 full with 9, out_ready[3] = 1, send sel=3 with in_data = e in the same cycle → in_ready = 1; next cycle out_valid[3] = 1, out_data3 = e.
- Streaming: out_ready = 1111, in_valid held 1, in_sel cycling 0..3, in_data 1..8 → one accept per cycle; each channel shows its word one cycle later.
- With DEMUX_STATS_EN: 300 accepts to channel 0 → ch_count[7:0] = 255, other channel counts = 0.
